// File: rtl/branch_predictor_if.sv
// Port bundle between the fetch/decode pipeline and the branch predictor.
// The master side drives fetch PCs and resolved-branch updates; the slave side is the predictor.
interface branch_predictor_if;
  logic [31:0] f_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_npc;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_npc;
  logic        mispredict;
  logic [31:0] correct_npc;
  logic [31:0] br_cnt;
  logic [31:0] mis_cnt;

  modport master (
    output f_pc, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_npc,
    input  pred_hit, pred_taken, pred_npc, mispredict, correct_npc, br_cnt, mis_cnt
  );

  modport slave (
    input  f_pc, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_npc,
    output pred_hit, pred_taken, pred_npc, mispredict, correct_npc, br_cnt, mis_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit saturating-counter predictor with stored targets: zero-latency
// fetch lookup, decode-stage update, mispredict detection and branch/mispredict counters.
module branch_predictor #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input logic               clk,
  input logic               reset,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_W;

  logic             valid_r  [ENTRIES];
  logic [TAG_W-1:0] tag_r    [ENTRIES];
  logic [31:0]      target_r [ENTRIES];
  logic [1:0]       ctr_r    [ENTRIES];
  logic [31:0]      br_cnt_r;
  logic [31:0]      mis_cnt_r;

  logic [IDX_W-1:0] f_idx_s;
  logic [TAG_W-1:0] f_tag_s;
  logic             pred_hit_s;
  logic             pred_taken_s;
  logic [31:0]      pred_npc_s;
  logic [IDX_W-1:0] u_idx_s;
  logic [TAG_W-1:0] u_tag_s;
  logic             u_hit_s;
  logic             mispredict_s;
  logic [31:0]      correct_npc_s;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    logic [1:0] n;
    case (c)
      2'b00:   n = 2'b01;
      2'b01:   n = 2'b10;
      2'b10:   n = 2'b11;
      2'b11:   n = 2'b11;
      default: n = 2'b01;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    logic [1:0] n;
    case (c)
      2'b00:   n = 2'b00;
      2'b01:   n = 2'b00;
      2'b10:   n = 2'b01;
      2'b11:   n = 2'b10;
      default: n = 2'b01;
    endcase
    return n;
  endfunction

  // Fetch lookup: reads pre-update table contents, no bypass from a same-cycle update.
  always_comb begin
    f_idx_s      = bp.f_pc[IDX_W+1:2];
    f_tag_s      = bp.f_pc[IDX_W+TAG_W+1:IDX_W+2];
    pred_hit_s   = valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s);
    pred_taken_s = pred_hit_s && ctr_r[f_idx_s][1];
    if (pred_taken_s) begin
      pred_npc_s = target_r[f_idx_s];
    end else begin
      pred_npc_s = bp.f_pc + 32'd4;
    end
  end

  // Decode-stage resolution: table hit for the update PC, mispredict and corrected PC.
  always_comb begin
    u_idx_s       = bp.upd_pc[IDX_W+1:2];
    u_tag_s       = bp.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    u_hit_s       = valid_r[u_idx_s] && (tag_r[u_idx_s] == u_tag_s);
    mispredict_s  = 1'b0;
    correct_npc_s = bp.upd_pc + 32'd8;
    if (bp.upd_en) begin
      mispredict_s = (bp.upd_taken != bp.upd_pred_taken) ||
                     (bp.upd_taken && bp.upd_pred_taken && (bp.upd_target != bp.upd_pred_npc));
    end else begin
      mispredict_s = 1'b0;
    end
    // The fall-through path skips the delay slot, hence +8.
    if (bp.upd_taken) begin
      correct_npc_s = bp.upd_target;
    end else begin
      correct_npc_s = bp.upd_pc + 32'd8;
    end
  end

  // Table and counter state: full clear on reset, otherwise one training update per resolved branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= 32'd0;
        ctr_r[i]    <= 2'b01;
      end
      br_cnt_r  <= 32'd0;
      mis_cnt_r <= 32'd0;
    end else if (bp.upd_en) begin
      if (u_hit_s) begin
        if (bp.upd_taken) begin
          ctr_r[u_idx_s]    <= ctr_inc(ctr_r[u_idx_s]);
          target_r[u_idx_s] <= bp.upd_target;
        end else begin
          ctr_r[u_idx_s] <= ctr_dec(ctr_r[u_idx_s]);
        end
      end else if (bp.upd_taken) begin
        // A taken miss replaces whatever occupied the slot, starting weakly taken.
        valid_r[u_idx_s]  <= 1'b1;
        tag_r[u_idx_s]    <= u_tag_s;
        target_r[u_idx_s] <= bp.upd_target;
        ctr_r[u_idx_s]    <= 2'b10;
      end else begin
        valid_r[u_idx_s] <= valid_r[u_idx_s];
      end
      br_cnt_r  <= br_cnt_r + 32'd1;
      mis_cnt_r <= mis_cnt_r + {31'd0, mispredict_s};
    end else begin
      br_cnt_r  <= br_cnt_r;
      mis_cnt_r <= mis_cnt_r;
    end
  end

  assign bp.pred_hit    = pred_hit_s;
  assign bp.pred_taken  = pred_taken_s;
  assign bp.pred_npc    = pred_npc_s;
  assign bp.mispredict  = mispredict_s;
  assign bp.correct_npc = correct_npc_s;
  assign bp.br_cnt      = br_cnt_r;
  assign bp.mis_cnt     = mis_cnt_r;
endmodule
